uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte producers (CPU APB path, GPIO event logger, debug sources).
- Accepts one byte at a time over valid/ready, with round-robin fairness.
- Sequences the UART tx_enable/data_in pair and waits for tx_done before granting the next byte.
- Watchdog timeout recovers from a UART that never completes; status outputs are visible to software via APB.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 65535;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        SEND = 2'b10
    } state_t;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = uart_pkg::DATA_W_DEF
);
    localparam int IW = uart_pkg::idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         uart_data_in;
    logic                      uart_tx_enable;
    logic                      uart_tx_done;
    logic [IW-1:0]             grant_id;
    logic                      busy;
    logic                      timeout_err;
    logic [15:0]               tx_count;

    modport master (
        output req_valid, req_data, uart_tx_done,
        input  req_ready, uart_data_in, uart_tx_enable,
        input  grant_id, busy, timeout_err, tx_count
    );

    modport slave (
        input  req_valid, req_data, uart_tx_done,
        output req_ready, uart_data_in, uart_tx_enable,
        output grant_id, busy, timeout_err, tx_count
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick, searching upward from last+1 with wrap.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = IW'((int'(last) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers, with watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input logic             pclk,
    input logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);

    state_t             state;
    logic [IW-1:0]      last;
    logic [IW-1:0]      win;
    logic [NUM_REQ-1:0] grant;
    logic               done_q;
    logic               done_edge;
    logic               fire;
    logic [15:0]        timer;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_valid),
        .last  (last),
        .grant (grant),
        .index (win)
    );

    // No handshake may complete while reset is held.
    assign fire          = rst_n && (state == IDLE) && (|bus.req_valid);
    assign bus.req_ready = fire ? grant : '0;
    assign done_edge     = bus.uart_tx_done & ~done_q;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            last               <= IW'(NUM_REQ - 1);
            done_q             <= 1'b0;
            timer              <= '0;
            bus.uart_data_in   <= '0;
            bus.uart_tx_enable <= 1'b0;
            bus.grant_id       <= '0;
            bus.timeout_err    <= 1'b0;
            bus.tx_count       <= '0;
        end else begin
            done_q <= bus.uart_tx_done;
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        bus.uart_data_in <= bus.req_data[int'(win)*DATA_W +: DATA_W];
                        bus.grant_id     <= win;
                        last             <= win;
                        state            <= ARM;
                    end
                end
                ARM: begin
                    timer              <= '0;
                    bus.uart_tx_enable <= 1'b1;
                    state              <= SEND;
                end
                SEND: begin
                    // Completion beats a watchdog expiry in the same cycle.
                    if (done_edge) begin
                        bus.uart_tx_enable <= 1'b0;
                        if (bus.tx_count != 16'hFFFF)
                            bus.tx_count <= bus.tx_count + 16'd1;
                        state <= IDLE;
                    end else if (timer == 16'(TIMEOUT_CYC - 1)) begin
                        bus.uart_tx_enable <= 1'b0;
                        bus.timeout_err    <= 1'b1;
                        state              <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    bus.uart_tx_enable <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (4 requesters, 16-cycle watchdog).
module tb_uart_tx_arbiter;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic pclk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_count;
    exp_t sb[$];

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    // Called in an IDLE cycle with valid already driven; returns in first SEND cycle.
    task automatic handshake(input int id, input logic [3:0] clr, input string tag);
        int   n;
        exp_t e;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << id));
        e.id   = id;
        e.data = bus.req_data[id*8 +: 8];
        sb.push_back(e);
        n = 0;
        tick;
        n++;
        bus.req_valid = bus.req_valid & ~clr;
        while (!bus.uart_tx_enable && n < 10) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_grant"}, 32'(bus.grant_id), 32'(e.id));
            chk({tag, "_data"}, 32'(bus.uart_data_in), 32'(e.data));
        end
    endtask

    task automatic done_pulse(input string tag);
        bus.uart_tx_done = 1'b1;
        tick;
        bus.uart_tx_done = 1'b0;
        exp_count++;
        chk({tag, "_en_off"}, 32'(bus.uart_tx_enable), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_count"}, 32'(bus.tx_count), 32'(exp_count));
    endtask

    initial begin
        int hi;
        checks = 0;
        errors = 0;
        exp_count = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.uart_tx_done = 1'b0;
        do_reset;

        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_data", 32'(bus.uart_data_in), 32'd0);
        chk("rst_en", 32'(bus.uart_tx_enable), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_count", 32'(bus.tx_count), 32'd0);

        // Single request
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid = 4'b0001;
        handshake(0, 4'b0001, "t1");
        chk("t1_busy", 32'(bus.busy), 32'd1);
        done_pulse("t1");

        // All valid continuously
        do_reset;
        bus.req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            handshake(i % 4, 4'b0000, $sformatf("t2_%0d", i));
            tick;
            chk($sformatf("t2_%0d_hold", i), 32'(bus.uart_tx_enable), 32'd1);
            chk($sformatf("t2_%0d_noready", i), 32'(bus.req_ready), 32'd0);
            done_pulse($sformatf("t2_%0d", i));
        end
        bus.req_valid = 4'b0000;

        // Fairness: make last=2, then 3 must win over 2
        bus.req_valid = 4'b0100;
        handshake(2, 4'b0100, "t3a");
        done_pulse("t3a");
        bus.req_valid = 4'b1100;
        handshake(3, 4'b1000, "t3b");
        done_pulse("t3b");
        handshake(2, 4'b0100, "t3c");
        done_pulse("t3c");

        // Watchdog timeout
        bus.req_data[15:8] = 8'h55;
        bus.req_valid = 4'b0010;
        handshake(1, 4'b0010, "t4");
        hi = 0;
        while (bus.uart_tx_enable && hi < 100) begin
            hi++;
            tick;
        end
        chk("t4_send_cycles", 32'(hi), 32'd16);
        chk("t4_err", 32'(bus.timeout_err), 32'd1);
        chk("t4_count", 32'(bus.tx_count), 32'(exp_count));
        chk("t4_idle", 32'(bus.busy), 32'd0);
        bus.req_data[7:0] = 8'h3C;
        bus.req_valid = 4'b0001;
        handshake(0, 4'b0001, "t4b");
        done_pulse("t4b");
        chk("t4_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Stale done level
        bus.req_data[15:8] = 8'h66;
        bus.req_valid = 4'b0010;
        handshake(1, 4'b0010, "t5a");
        bus.uart_tx_done = 1'b1;
        tick;
        exp_count++;
        chk("t5a_count", 32'(bus.tx_count), 32'(exp_count));
        bus.req_data[23:16] = 8'h77;
        bus.req_valid = 4'b0100;
        handshake(2, 4'b0100, "t5b");
        repeat (5) tick;
        chk("t5b_stale_en", 32'(bus.uart_tx_enable), 32'd1);
        chk("t5b_stale_count", 32'(bus.tx_count), 32'(exp_count));
        bus.uart_tx_done = 1'b0;
        tick;
        done_pulse("t5b");

        // Asynchronous reset in SEND
        bus.req_data[31:24] = 8'h99;
        bus.req_valid = 4'b1000;
        handshake(3, 4'b1000, "t6");
        #2;
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_data", 32'(bus.uart_data_in), 32'd0);
        chk("t6_en", 32'(bus.uart_tx_enable), 32'd0);
        chk("t6_grant", 32'(bus.grant_id), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_err", 32'(bus.timeout_err), 32'd0);
        chk("t6_count", 32'(bus.tx_count), 32'd0);
        tick;
        rst_n = 1'b1;
        exp_count = 0;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        handshake(0, 4'b1111, "t6b");
        done_pulse("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
